// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the multi-cycle signed multiply sequencer.
// Holds the state encoding, the ALU control code and the default operand width.
package mult_sequencer_pkg;

   localparam int         DEFAULT_WIDTH = 32;
   localparam logic [3:0] ALUCTRL_MULT  = 4'b0011;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      SIGN = 2'b10,
      DONE = 2'b11
   } state_t;

endpackage

// File: rtl/mult_dp.sv
// Multiply datapath: operand magnitudes, shift-add accumulator, iteration count, final negate.
// Product registers update only on i_write; o_skip is active only when EARLY_TERM is set.
module mult_dp
   import mult_sequencer_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter bit EARLY_TERM = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_write,
   input  logic [WIDTH-1:0] i_src1,
   input  logic [WIDTH-1:0] i_src2,
   output logic             o_last,
   output logic             o_skip,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mplier;
   logic [CW-1:0]      r_count;
   logic               r_neg;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic [WIDTH-1:0]   w_abs1;
   logic [WIDTH-1:0]   w_abs2;
   logic [2*WIDTH-1:0] w_sum;
   logic [2*WIDTH-1:0] w_prod;

   // The most negative operand negates to itself, which is exactly 2^(WIDTH-1) read unsigned.
   assign w_abs1 = i_src1[WIDTH-1] ? -i_src1 : i_src1;
   assign w_abs2 = i_src2[WIDTH-1] ? -i_src2 : i_src2;
   assign w_sum  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_prod = r_neg ? -r_acc : r_acc;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_count  <= '0;
         r_neg    <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         if (i_load) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_abs1};
            r_mplier <= w_abs2;
            r_neg    <= i_src1[WIDTH-1] ^ i_src2[WIDTH-1];
            r_acc    <= '0;
            r_count  <= '0;
         end else if (i_step) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + 1'b1;
         end
         if (i_write) begin
            {r_hi, r_lo} <= w_prod;
         end
      end
   end

   assign o_last = (r_count == LAST);
   assign o_skip = EARLY_TERM && (r_mplier == '0);
   assign o_hi   = r_hi;
   assign o_lo   = r_lo;

endmodule

// File: rtl/mult_sequencer.sv
// Signed radix-2 shift-add multiply sequencer for the mult instruction; stalls the pipe via busy_o.
// Optional early termination on an exhausted multiplier is enabled with MULT_EARLY_TERM_EN.
module mult_sequencer
   import mult_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

`ifdef MULT_EARLY_TERM_EN
   localparam bit EARLY_TERM = 1'b1;
`else
   localparam bit EARLY_TERM = 1'b0;
`endif

   state_t r_state;
   state_t w_next;
   logic   w_load;
   logic   w_step;
   logic   w_write;
   logic   w_last;
   logic   w_skip;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_load  = 1'b0;
      w_step  = 1'b0;
      w_write = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i && !flush_i) begin
               w_load = 1'b1;
               w_next = CALC;
            end
         end
         CALC: begin
            if (flush_i) begin
               w_next = IDLE;
            end else if (w_skip) begin
               w_next = SIGN;
            end else begin
               w_step = 1'b1;
               if (w_last) begin
                  w_next = SIGN;
               end
            end
         end
         SIGN: begin
            // A flush here drops the result so the product registers keep the last good value.
            if (flush_i) begin
               w_next = IDLE;
            end else begin
               w_write = 1'b1;
               w_next  = DONE;
            end
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   assign busy_o = (r_state == CALC) || (r_state == SIGN);
   assign done_o = (r_state == DONE);

   mult_dp #(
      .WIDTH      (WIDTH),
      .EARLY_TERM (EARLY_TERM)
   ) u_dp (
      .i_clk   (clk_i),
      .i_rst_n (rst_i),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_write (w_write),
      .i_src1  (src1_i),
      .i_src2  (src2_i),
      .o_last  (w_last),
      .o_skip  (w_skip),
      .o_hi    (hi_o),
      .o_lo    (lo_o)
   );

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: timing/product model checked every cycle plus directed literal cases.
module tb_mult_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        flush;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        busy_o;
   logic        done_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_checks = 0;
   int n_errors = 0;
   int n_done   = 0;
   int cyc      = 0;

`ifdef MULT_EARLY_TERM_EN
   localparam int LAT_3X5   = 6;
   localparam int LAT_N7X6  = 6;
   localparam int LAT_9X2   = 5;
   localparam int LAT_9X0   = 3;
`else
   localparam int LAT_3X5   = 34;
   localparam int LAT_N7X6  = 34;
   localparam int LAT_9X2   = 34;
   localparam int LAT_9X0   = 34;
`endif
   localparam int LAT_FULL = 34;

   mult_sequencer #(.WIDTH(32)) dut (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .start_i (start),
      .flush_i (flush),
      .src1_i  (src1),
      .src2_i  (src2),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .hi_o    (hi_o),
      .lo_o    (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
      longint pa, pb;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
   endfunction

   function automatic int ref_lat(input logic [31:0] b);
`ifdef MULT_EARLY_TERM_EN
      logic [31:0] mag;
      int          msb;
      mag = b[31] ? -b : b;
      if (mag == 32'd0) return 3;
      msb = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) msb = i;
      return (msb + 4 < 34) ? msb + 4 : 34;
`else
      return (b === 32'hx) ? 0 : 34;
`endif
   endfunction

   // Model: an accepted start completes L cycles later unless flushed before its DONE cycle.
   logic        m_valid  = 1'b0;
   logic        m_active = 1'b0;
   int          m_done_cyc = 0;
   logic [63:0] m_pend = '0;
   logic [63:0] m_prod = '0;
   logic        exp_busy = 1'b0;
   logic        exp_done = 1'b0;

   always @(posedge clk) begin
      logic was_active;
      int   c;
      c = cyc;
      if (!rst_n) begin
         m_active = 1'b0;
         m_prod   = '0;
      end else begin
         was_active = m_active;
         if (m_active) begin
            if (c == m_done_cyc)            m_active = 1'b0;
            else if (flush)                 m_active = 1'b0;
            else if (c == m_done_cyc - 1)   m_prod   = m_pend;
         end
         if (!was_active && start && !flush) begin
            m_active   = 1'b1;
            m_done_cyc = c + ref_lat(src2);
            m_pend     = ref_prod(src1, src2);
         end
      end
      cyc      = c + 1;
      exp_busy = m_active && (cyc < m_done_cyc);
      exp_done = m_active && (cyc == m_done_cyc);
      m_valid  = 1'b1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done_o === 1'b1) n_done++;
      if (m_valid) begin
         chk("model_busy", {63'd0, busy_o}, {63'd0, exp_busy});
         chk("model_done", {63'd0, done_o}, {63'd0, exp_done});
         chk("model_prod", {hi_o, lo_o}, m_prod);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input int e_lat);
      int   n, busy_cnt, lat;
      logic seen;
      src1 = a;
      src2 = b;
      start = 1'b1;
      n = cyc;
      next_cycle();
      start = 1'b0;
      busy_cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (busy_o) busy_cnt++;
         if (done_o) seen = 1'b1;
      end
      lat = cyc - n;
      if (!seen) begin
         chk({name, "_timeout"}, 64'd0, 64'd1);
      end else begin
         chk({name, "_lat"}, 64'(lat), 64'(e_lat));
         chk({name, "_busycnt"}, 64'(busy_cnt), 64'(e_lat - 1));
         chk({name, "_hi"}, {32'd0, hi_o}, {32'd0, e_hi});
         chk({name, "_lo"}, {32'd0, lo_o}, {32'd0, e_lo});
      end
      next_cycle();
   endtask

   initial begin
      int n, d0;
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      src1  = '0;
      src2  = '0;
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_busy", {63'd0, busy_o}, 64'd0);
      chk("rst_done", {63'd0, done_o}, 64'd0);
      chk("rst_prod", {hi_o, lo_o}, 64'd0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      run_mul("3x5", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, LAT_3X5);
      run_mul("m7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, LAT_N7X6);
      run_mul("min_sq", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, LAT_FULL);

      // Flush mid-calculation, then restart two cycles later.
      d0 = n_done;
      src1 = 32'd3;
      src2 = 32'h7FFF_FFFF;
      start = 1'b1;
      n = cyc;
      next_cycle();
      start = 1'b0;
      while (cyc < n + 10) next_cycle();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", {63'd0, busy_o}, 64'd0);
      chk("flush_prod_kept", {hi_o, lo_o}, 64'h4000_0000_0000_0000);
      next_cycle();
      run_mul("after_flush", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F, LAT_3X5);
      chk("flush_no_done", 64'(n_done - d0), 64'd1);

      // Start held high through a whole operation: one done per accepted start.
      d0 = n_done;
      src1 = 32'd3;
      src2 = 32'h7FFF_FFFF;
      start = 1'b1;
      for (int i = 0; i < 40; i++) next_cycle();
      start = 1'b0;
      chk("hold_one_done", 64'(n_done - d0), 64'd1);
      chk("hold_prod", {hi_o, lo_o}, 64'h0000_0001_7FFF_FFFD);
      for (int i = 0; i < 40; i++) next_cycle();

      // Reset asserted mid-calculation.
      d0 = n_done;
      src1 = 32'd3;
      src2 = 32'h7FFF_FFFF;
      start = 1'b1;
      n = cyc;
      next_cycle();
      start = 1'b0;
      while (cyc < n + 5) next_cycle();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {63'd0, busy_o}, 64'd0);
      chk("midrst_done", {63'd0, done_o}, 64'd0);
      chk("midrst_prod", {hi_o, lo_o}, 64'd0);
      for (int i = 0; i < 40; i++) next_cycle();
      chk("midrst_no_done", 64'(n_done - d0), 64'd0);

      run_mul("9x2", 32'd9, 32'd2, 32'h0000_0000, 32'h0000_0012, LAT_9X2);
      run_mul("9x0", 32'd9, 32'd0, 32'h0000_0000, 32'h0000_0000, LAT_9X0);
      run_mul("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, LAT_FULL);

      next_cycle();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle signed multiply sequencer for the `mult` instruction, ALU control code 4'b0011.
- Accepts two WIDTH-bit operands on a start pulse and runs a radix-2 shift-add loop.
- Produces a 2*WIDTH-bit product on hi_o/lo_o and stalls the pipeline while busy.
- Sits beside the ALU in the execute stage. The decoder/ALU-control path drives start_i; the hazard unit consumes busy_o.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  begin a multiply; sampled only in IDLE.
- flush_i  in  1  abort any in-flight multiply.
- src1_i  in  WIDTH  multiplicand, two's complement.
- src2_i  in  WIDTH  multiplier, two's complement.
- busy_o  out  1  high in CALC and SIGN.
- done_o  out  1  one-cycle pulse in DONE; hi_o/lo_o valid from this cycle.
- hi_o  out  WIDTH  upper product half, registered.
- lo_o  out  WIDTH  lower product half, registered.

## Operation
- FSM states: IDLE, CALC, SIGN, DONE.
- IDLE, start_i=1 and flush_i=0:
  - latch mcand = |src1_i| zero-extended to 2*WIDTH, and mplier = |src2_i| (WIDTH bits).
  - latch neg = src1_i[MSB]^src2_i[MSB]; clear acc (2*WIDTH) and count; go to CALC.
- |x| of the most negative value equals 2^(WIDTH-1), which fits unsigned WIDTH bits. No special case.
- CALC, each cycle:
  - if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, count++.
  - after WIDTH iterations (count==WIDTH-1 processed), go to SIGN.
- SIGN: write {hi_o,lo_o} = neg ? -acc : acc (2*WIDTH two's complement); go to DONE.
- DONE: done_o=1; return to IDLE. start_i is ignored in DONE.
- hi_o/lo_o hold their value until the next SIGN write.
- start_i is ignored while not in IDLE. No queuing.
- flush_i=1 in CALC or SIGN: go to IDLE next edge; no done_o; hi_o/lo_o unchanged.
- flush_i=1 in IDLE blocks start_i. flush_i in DONE has no effect: the pulse completes.
- rst_i=0 at any edge, including mid-CALC: go to IDLE; hi_o=lo_o=0, busy_o=0, done_o=0, internal regs 0.

## Timing
- start_i sampled in cycle N:
  - CALC in cycles N+1..N+WIDTH.
  - SIGN in N+WIDTH+1.
  - done_o high in N+WIDTH+2 (34 cycles for WIDTH=32).
- busy_o high in cycles N+1..N+WIDTH+1; low in DONE.
- Back-to-back: the earliest next start_i is sampled in the DONE cycle's following IDLE cycle (N+WIDTH+3).
- Outputs are purely registered or state-decoded. No combinational path from inputs to outputs.

## Configuration
- MULT_EARLY_TERM_EN defined:
  - in CALC, if mplier==0 at the start of the cycle, do no add and go to SIGN.
  - latency = 3 + (index of highest set bit of |src2_i|) + 1 cycles to done_o; a zero multiplier gives done_o at N+3.
- Undefined: fixed WIDTH+2 latency for all operands. Results are identical in both builds.

## Structure
- Shared package holds:
  - state encoding (2-bit enum IDLE/CALC/SIGN/DONE);
  - ALUCTRL_MULT = 4'b0011;
  - default WIDTH constant.
- One natural sub-module, mult_dp: the operand, accumulator and count registers, the adder and the final negate. The FSM and handshake stay in mult_sequencer.

## Test plan
- 3 × 5, macro off: done_o at N+34, hi_o=0x00000000, lo_o=0x0000000F, busy_o high N+1..N+33.
- −7 × 6: hi_o=0xFFFFFFFF, lo_o=0xFFFFFFD6; 0x80000000 × 0x80000000: hi_o=0x40000000, lo_o=0x00000000.
- Start 3 × 5, then flush_i at N+10: busy_o low at N+11, no done_o, hi_o/lo_o keep their prior values; a new start at N+12 completes normally.
- start_i held high during busy: only one done_o per accepted start. rst_i low at N+5: all outputs 0 next cycle; FSM in IDLE.
- MULT_EARLY_TERM_EN on, 9 × 2: done_o at N+5, lo_o=0x12; 9 × 0: done_o at N+3, product 0. Same operands with macro off: done_o at N+34 with identical product.
